// File: rtl/cc_level_sequencer_pkg.sv
// Shared level codes, level lengths and sequencer state encoding.
// Imported by the sequencer, its length LUT and the data handler.
package cc_level_sequencer_pkg;

  localparam int CL_W  = 3;
  localparam int LP_W  = 5;

  localparam logic [CL_W-1:0] LVL_IDLE = 3'd0;
  localparam logic [CL_W-1:0] LVL_1    = 3'd2;
  localparam logic [CL_W-1:0] LVL_2    = 3'd4;
  localparam logic [CL_W-1:0] LVL_3    = 3'd6;
  localparam logic [CL_W-1:0] LVL_STEP = 3'd2;

  localparam int LEN_1       = 10;
  localparam int LEN_2       = 15;
  localparam int LEN_3       = 20;
  localparam int INTER_TICKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_INTER = 3'd3,
    ST_WON   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/cc_level_sequencer_length_lut.sv
// Level code to row-count lookup.
// Purely combinational; unknown codes map to a zero length.
module cc_level_sequencer_length_lut
  import cc_level_sequencer_pkg::*;
#(
  parameter int CURRENTLEVEL_DATAWIDTH  = CL_W,
  parameter int LEVELPROGRESS_DATAWIDTH = LP_W,
  parameter int LEVEL1_LENGTH           = LEN_1,
  parameter int LEVEL2_LENGTH           = LEN_2,
  parameter int LEVEL3_LENGTH           = LEN_3
) (
  input  logic [CURRENTLEVEL_DATAWIDTH-1:0]  i_lvl,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] o_len
);

  localparam int CW = CURRENTLEVEL_DATAWIDTH;
  localparam int PW = LEVELPROGRESS_DATAWIDTH;

  // Decode the level code into its row count
  always_comb begin
    o_len = '0;
    unique case (1'b1)
      (i_lvl == CW'(LVL_1)): o_len = PW'(LEVEL1_LENGTH);
      (i_lvl == CW'(LVL_2)): o_len = PW'(LEVEL2_LENGTH);
      (i_lvl == CW'(LVL_3)): o_len = PW'(LEVEL3_LENGTH);
      default:               o_len = '0;
    endcase
  end

endmodule

// File: rtl/cc_level_sequencer.sv
// Level sequencer: steps row index through three levels with
// interlevel gaps, pause, collision restart and a won state.
module cc_level_sequencer
  import cc_level_sequencer_pkg::*;
#(
  parameter int CURRENTLEVEL_DATAWIDTH  = CL_W,
  parameter int LEVELPROGRESS_DATAWIDTH = LP_W,
  parameter int LEVEL1_LENGTH           = LEN_1,
  parameter int LEVEL2_LENGTH           = LEN_2,
  parameter int LEVEL3_LENGTH           = LEN_3,
  parameter int INTERLEVEL_TICKS        = INTER_TICKS
) (
  input  logic CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic CC_LEVEL_SEQUENCER_Start,
  input  logic CC_LEVEL_SEQUENCER_Tick,
  input  logic CC_LEVEL_SEQUENCER_Pause,
  input  logic CC_LEVEL_SEQUENCER_Collision,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_CurrentLvl,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LvlProgress,
  output logic CC_LEVEL_SEQUENCER_LoadRow,
  output logic CC_LEVEL_SEQUENCER_LevelDone,
  output logic CC_LEVEL_SEQUENCER_GameWon
);

  localparam int CW  = CURRENTLEVEL_DATAWIDTH;
  localparam int PW  = LEVELPROGRESS_DATAWIDTH;
  localparam int NW  = $clog2(INTERLEVEL_TICKS + 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(INTERLEVEL_TICKS - 1);

  seq_state_e    r_state, w_nstate;
  logic [CW-1:0] r_lvl,   w_nlvl;
  logic [PW-1:0] r_prog,  w_nprog;
  logic [NW-1:0] r_cnt,   w_ncnt;
  logic          r_load,  w_nload;
  logic          r_done,  w_ndone;
  logic          r_won,   w_nwon;
  logic [PW-1:0] w_len;

  cc_level_sequencer_length_lut #(
    .CURRENTLEVEL_DATAWIDTH  (CW),
    .LEVELPROGRESS_DATAWIDTH (PW),
    .LEVEL1_LENGTH           (LEVEL1_LENGTH),
    .LEVEL2_LENGTH           (LEVEL2_LENGTH),
    .LEVEL3_LENGTH           (LEVEL3_LENGTH)
  ) u_lut (
    .i_lvl (r_lvl),
    .o_len (w_len)
  );

  // Next state and next registered outputs, Start first
  always_comb begin
    w_nstate = r_state;
    w_nlvl   = r_lvl;
    w_nprog  = r_prog;
    w_ncnt   = r_cnt;
    w_nload  = 1'b0;
    w_ndone  = 1'b0;
    if (CC_LEVEL_SEQUENCER_Start) begin
      w_nstate = ST_RUN;
      w_nlvl   = CW'(LVL_1);
      w_nprog  = PW'(1);
      w_ncnt   = '0;
      w_nload  = 1'b1;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (CC_LEVEL_SEQUENCER_Collision) begin
            w_nprog = PW'(1);
            w_nload = 1'b1;
          end else if (CC_LEVEL_SEQUENCER_Pause) begin
            w_nstate = ST_PAUSE;
          end else if (CC_LEVEL_SEQUENCER_Tick) begin
            if (r_prog < w_len) begin
              w_nprog = r_prog + PW'(1);
              w_nload = 1'b1;
            end else begin
              w_nprog = '0;
              w_ndone = 1'b1;
              w_ncnt  = '0;
              w_nstate = (r_lvl < CW'(LVL_3))
                       ? ST_INTER : ST_WON;
            end
          end
        end
        ST_PAUSE: begin
          if (CC_LEVEL_SEQUENCER_Collision) begin
            w_nprog = PW'(1);
            w_nload = 1'b1;
          end else if (!CC_LEVEL_SEQUENCER_Pause) begin
            w_nstate = ST_RUN;
          end
        end
        ST_INTER: begin
          if (CC_LEVEL_SEQUENCER_Tick) begin
            if (r_cnt >= CNT_LAST) begin
              w_nstate = ST_RUN;
              w_nlvl   = r_lvl + CW'(LVL_STEP);
              w_nprog  = PW'(1);
              w_nload  = 1'b1;
              w_ncnt   = '0;
            end else begin
              w_ncnt = r_cnt + NW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
    w_nwon = (w_nstate == ST_WON);
  end

  // State and output registers, cleared by async reset
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or
              negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_lvl   <= CW'(LVL_IDLE);
      r_prog  <= '0;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_won   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_lvl   <= w_nlvl;
      r_prog  <= w_nprog;
      r_cnt   <= w_ncnt;
      r_load  <= w_nload;
      r_done  <= w_ndone;
      r_won   <= w_nwon;
    end
  end

  assign CC_LEVEL_SEQUENCER_CurrentLvl  = r_lvl;
  assign CC_LEVEL_SEQUENCER_LvlProgress = r_prog;
  assign CC_LEVEL_SEQUENCER_LoadRow     = r_load;
  assign CC_LEVEL_SEQUENCER_LevelDone   = r_done;
  assign CC_LEVEL_SEQUENCER_GameWon     = r_won;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Directed bench for cc_level_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_cc_level_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, tick, pause, coll;
  logic [2:0] lvl;
  logic [4:0] prog;
  logic       load, done, won;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50    (clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow (rst_n),
    .CC_LEVEL_SEQUENCER_Start       (start),
    .CC_LEVEL_SEQUENCER_Tick        (tick),
    .CC_LEVEL_SEQUENCER_Pause       (pause),
    .CC_LEVEL_SEQUENCER_Collision   (coll),
    .CC_LEVEL_SEQUENCER_CurrentLvl  (lvl),
    .CC_LEVEL_SEQUENCER_LvlProgress (prog),
    .CC_LEVEL_SEQUENCER_LoadRow     (load),
    .CC_LEVEL_SEQUENCER_LevelDone   (done),
    .CC_LEVEL_SEQUENCER_GameWon     (won)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input int l, input int p,
                      input bit ld, input bit dn,
                      input bit w);
    chk({tag, ".lvl"},  8'(lvl),  8'(l));
    chk({tag, ".prog"}, 8'(prog), 8'(p));
    chk({tag, ".load"}, 8'(load), 8'(ld));
    chk({tag, ".done"}, 8'(done), 8'(dn));
    chk({tag, ".won"},  8'(won),  8'(w));
  endtask

  task automatic step(input bit s, input bit t,
                      input bit p, input bit c);
    @(negedge clk);
    start = s; tick = t; pause = p; coll = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; tick = 0; pause = 0; coll = 0;
    repeat (2) @(posedge clk);
    #1 outs("rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    outs("idle_hold", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0);
    outs("start", 2, 1, 1, 0, 0);
    step(0, 0, 0, 0);
    outs("no_tick", 2, 1, 0, 0, 0);
    for (int i = 2; i <= 10; i++) begin
      step(0, 1, 0, 0);
      chk("l1_prog", 8'(prog), 8'(i));
      chk("l1_load", 8'(load), 8'd1);
    end
    step(0, 1, 0, 0);
    outs("l1_done", 2, 0, 0, 1, 0);

    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    outs("inter3", 2, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    outs("l2_enter", 4, 1, 1, 0, 0);

    for (int i = 2; i <= 9; i++) step(0, 1, 0, 0);
    chk("l2_at9", 8'(prog), 8'd9);
    step(0, 1, 0, 1);
    outs("coll_tick", 4, 1, 1, 0, 0);
    step(0, 0, 0, 0);
    outs("coll_once", 4, 1, 0, 0, 0);

    for (int i = 2; i <= 7; i++) step(0, 1, 0, 0);
    chk("l2_at7", 8'(prog), 8'd7);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0);
      chk("pause_prog", 8'(prog), 8'd7);
      chk("pause_load", 8'(load), 8'd0);
    end
    step(0, 0, 0, 0);
    outs("unpause", 4, 7, 0, 0, 0);
    step(0, 1, 0, 0);
    outs("after_pause", 4, 8, 1, 0, 0);

    for (int i = 9; i <= 15; i++) step(0, 1, 0, 0);
    outs("l2_at15", 4, 15, 1, 0, 0);
    step(0, 1, 0, 0);
    outs("l2_done", 4, 0, 0, 1, 0);
    repeat (4) step(0, 1, 0, 0);
    outs("l3_enter", 6, 1, 1, 0, 0);

    for (int i = 2; i <= 20; i++) step(0, 1, 0, 0);
    outs("l3_at20", 6, 20, 1, 0, 0);
    step(0, 1, 0, 0);
    outs("l3_done", 6, 0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    outs("won_hold", 6, 0, 0, 0, 1);

    step(1, 0, 0, 0);
    outs("restart", 2, 1, 1, 0, 0);
    for (int i = 2; i <= 5; i++) step(0, 1, 0, 0);
    step(1, 0, 1, 1);
    outs("start_prio", 2, 1, 1, 0, 0);
    for (int i = 2; i <= 11; i++) step(0, 1, 0, 0);
    outs("l1_done2", 2, 0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    @(negedge clk) rst_n = 1'b0;
    #1 outs("async_rst", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    outs("in_rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    outs("post_rst", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    outs("start2", 2, 1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("cnt_clear", 8'(prog), 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
